// File: rtl/logic_gate_sweep_if.sv
// Bundles the operand, result and sweep-control signals of logic_gate_sweep.
// Ports: mode/in_valid/in_data/sweep_start are driven by the master side.
//        in_ready/out_*/sweep_busy/sweep_done/ones_count are driven by the slave (gate).
interface logic_gate_sweep_if #(
  parameter int WIDTH = 2
);
  logic [2:0]       mode;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             sweep_start;
  logic             out_valid;
  logic             out_bit;
  logic [WIDTH-1:0] out_vec;
  logic             sweep_busy;
  logic             sweep_done;
  logic [WIDTH:0]   ones_count;

  modport master (
    output mode, in_valid, in_data, sweep_start,
    input  in_ready, out_valid, out_bit, out_vec, sweep_busy, sweep_done, ones_count
  );

  modport slave (
    input  mode, in_valid, in_data, sweep_start,
    output in_ready, out_valid, out_bit, out_vec, sweep_busy, sweep_done, ones_count
  );
endinterface

// File: rtl/logic_gate_sweep.sv
// Purpose: WIDTH-input configurable reduction gate with a registered output and an
//          exhaustive truth-table sweep engine that counts the 1 results.
// Latency: 1 cycle per operand; a sweep emits 2^WIDTH results, sweep_done 2^WIDTH
//          cycles after the sweep_start edge. Backpressure: none on the output;
//          in_ready drops while sweeping or when sweep_start is requested.
// Ports:   clk, rst_n (async active-low), bus (logic_gate_sweep_if.slave).
module logic_gate_sweep #(
  parameter int WIDTH = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  logic_gate_sweep_if.slave   bus
);

  if (WIDTH < 2 || WIDTH > 8) begin : g_bad_width
    $error("logic_gate_sweep: WIDTH must be in 2..8");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [2:0]       sweep_mode_q, sweep_mode_d;
  logic             out_valid_q, out_valid_d;
  logic             out_bit_q, out_bit_d;
  logic [WIDTH-1:0] out_vec_q, out_vec_d;
  logic             sweep_done_q, sweep_done_d;
  logic [WIDTH:0]   ones_q, ones_d;
  logic             sweep_bit;

  // Reduction over every input bit; reserved encodings evaluate to 0.
  function automatic logic gate_eval(input logic [2:0] m, input logic [WIDTH-1:0] v);
    case (m)
      3'b000:  return &v;
      3'b001:  return |v;
      3'b010:  return ~&v;
      3'b011:  return ~|v;
      3'b100:  return ^v;
      3'b101:  return ~^v;
      default: return 1'b0;
    endcase
  endfunction

  // sweep_start wins over a simultaneous operand: the operand is refused, not queued.
  assign bus.in_ready   = (state_q == IDLE) && !bus.sweep_start;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_bit    = out_bit_q;
  assign bus.out_vec    = out_vec_q;
  assign bus.sweep_busy = (state_q == SWEEP);
  assign bus.sweep_done = sweep_done_q;
  assign bus.ones_count = ones_q;

  // Sweep results use the mode latched at sweep start, never the live mode input.
  assign sweep_bit = gate_eval(sweep_mode_q, cnt_q);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    sweep_mode_d = sweep_mode_q;
    out_valid_d  = 1'b0;
    out_bit_d    = out_bit_q;
    out_vec_d    = out_vec_q;
    sweep_done_d = 1'b0;
    ones_d       = ones_q;

    case (state_q)
      IDLE: begin
        if (bus.sweep_start) begin
          state_d      = SWEEP;
          sweep_mode_d = bus.mode;
          cnt_d        = '0;
          ones_d       = '0;
        end else if (bus.in_valid) begin
          out_valid_d = 1'b1;
          out_vec_d   = bus.in_data;
          out_bit_d   = gate_eval(bus.mode, bus.in_data);
        end
      end
      SWEEP: begin
        out_valid_d = 1'b1;
        out_vec_d   = cnt_q;
        out_bit_d   = sweep_bit;
        ones_d      = ones_q + (WIDTH+1)'(sweep_bit);
        cnt_d       = cnt_q + 1'b1;
        // The all-ones vector is the last one; the counter wraps to 0 behind it.
        if (cnt_q == {WIDTH{1'b1}}) begin
          state_d      = IDLE;
          sweep_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      sweep_mode_q <= '0;
      out_valid_q  <= 1'b0;
      out_bit_q    <= 1'b0;
      out_vec_q    <= '0;
      sweep_done_q <= 1'b0;
      ones_q       <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sweep_mode_q <= sweep_mode_d;
      out_valid_q  <= out_valid_d;
      out_bit_q    <= out_bit_d;
      out_vec_q    <= out_vec_d;
      sweep_done_q <= sweep_done_d;
      ones_q       <= ones_d;
    end
  end

endmodule

// File: tb/tb_logic_gate_sweep.sv
// Directed bench for logic_gate_sweep at WIDTH 2, 3 and 4 sharing one clock/reset.
// Inputs change 1 time unit after the rising edge; outputs are checked at that point.
// Ports: none (top-level bench).
module tb_logic_gate_sweep;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  logic_gate_sweep_if #(.WIDTH(2)) if2 ();
  logic_gate_sweep_if #(.WIDTH(3)) if3 ();
  logic_gate_sweep_if #(.WIDTH(4)) if4 ();

  logic_gate_sweep #(.WIDTH(2)) u_w2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));
  logic_gate_sweep #(.WIDTH(3)) u_w3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));
  logic_gate_sweep #(.WIDTH(4)) u_w4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Normal-mode vectors: mode, operand, expected result.
  logic [2:0] nm_mode [8] = '{3'b000, 3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b110, 3'b111};
  logic [1:0] nm_data [8] = '{2'b11,  2'b10,  2'b00,  2'b11,  2'b01,  2'b01,  2'b11,  2'b11};
  logic       nm_exp  [8] = '{1'b1,   1'b0,   1'b0,   1'b0,   1'b1,   1'b0,   1'b0,   1'b0};

  logic [3:0]  nor2_tt = 4'b0001;       // NOR over 2 bits: only vector 00 gives 1
  logic [7:0]  xor3_tt = 8'b1001_0110;  // odd parity over 3 bits
  logic [15:0] or4_tt  = 16'hFFFE;      // OR over 4 bits: only vector 0000 gives 0

  initial begin
    if2.mode = 3'b000; if2.in_valid = 1'b0; if2.in_data = '0; if2.sweep_start = 1'b0;
    if3.mode = 3'b000; if3.in_valid = 1'b0; if3.in_data = '0; if3.sweep_start = 1'b0;
    if4.mode = 3'b000; if4.in_valid = 1'b0; if4.in_data = '0; if4.sweep_start = 1'b0;

    // Reset state
    step(); step();
    chk("rst_out_valid", 32'(if2.out_valid), 32'd0);
    chk("rst_out_bit",   32'(if2.out_bit),   32'd0);
    chk("rst_out_vec",   32'(if2.out_vec),   32'd0);
    chk("rst_busy",      32'(if2.sweep_busy), 32'd0);
    chk("rst_done",      32'(if2.sweep_done), 32'd0);
    chk("rst_ones",      32'(if2.ones_count), 32'd0);
    chk("rst_in_ready",  32'(if2.in_ready),  32'd1);
    rst_n = 1'b1;
    step();
    chk("post_rst_in_ready", 32'(if2.in_ready), 32'd1);

    // W2 NOR sweep
    if2.mode = 3'b011; if2.sweep_start = 1'b1;
    #1;
    chk("start_blocks_ready", 32'(if2.in_ready), 32'd0);
    step();
    if2.sweep_start = 1'b0;
    chk("w2_busy_after_start",  32'(if2.sweep_busy), 32'd1);
    chk("w2_valid_after_start", 32'(if2.out_valid),  32'd0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("w2nor_valid%0d", k), 32'(if2.out_valid), 32'd1);
      chk($sformatf("w2nor_vec%0d", k),   32'(if2.out_vec),   32'(k));
      chk($sformatf("w2nor_bit%0d", k),   32'(if2.out_bit),   32'(nor2_tt[k]));
      chk($sformatf("w2nor_done%0d", k),  32'(if2.sweep_done), 32'(k == 3));
      chk($sformatf("w2nor_busy%0d", k),  32'(if2.sweep_busy), 32'(k != 3));
    end
    chk("w2nor_ones", 32'(if2.ones_count), 32'd1);
    step();
    chk("w2nor_valid_end", 32'(if2.out_valid),  32'd0);
    chk("w2nor_done_end",  32'(if2.sweep_done), 32'd0);
    chk("w2nor_ones_hold", 32'(if2.ones_count), 32'd1);

    // W2 normal mode NOR, back-to-back
    if2.in_valid = 1'b1; if2.in_data = 2'b10;
    step();
    if2.in_data = 2'b00;
    chk("nor_b2b_valid0", 32'(if2.out_valid), 32'd1);
    chk("nor_b2b_bit0",   32'(if2.out_bit),   32'd0);
    chk("nor_b2b_vec0",   32'(if2.out_vec),   32'd2);
    step();
    if2.in_valid = 1'b0;
    chk("nor_b2b_valid1", 32'(if2.out_valid), 32'd1);
    chk("nor_b2b_bit1",   32'(if2.out_bit),   32'd1);
    chk("nor_b2b_vec1",   32'(if2.out_vec),   32'd0);
    step();
    chk("nor_b2b_valid2", 32'(if2.out_valid), 32'd0);
    chk("normal_ones_untouched", 32'(if2.ones_count), 32'd1);

    // W2 normal-mode table, including reserved encodings
    for (int i = 0; i < 8; i++) begin
      if2.mode = nm_mode[i]; if2.in_data = nm_data[i]; if2.in_valid = 1'b1;
      step();
      if2.in_valid = 1'b0;
      chk($sformatf("nm_valid%0d", i), 32'(if2.out_valid), 32'd1);
      chk($sformatf("nm_bit%0d", i),   32'(if2.out_bit),   32'(nm_exp[i]));
    end
    step();

    // W3 reduction must cover every bit
    if3.mode = 3'b000; if3.in_data = 3'b011; if3.in_valid = 1'b1;
    step();
    chk("w3_and_011", 32'(if3.out_bit), 32'd0);
    if3.mode = 3'b100; if3.in_data = 3'b111;
    step();
    if3.in_valid = 1'b0;
    chk("w3_xor_111", 32'(if3.out_bit), 32'd1);

    // W3 XOR sweep with a mid-sweep mode change
    if3.mode = 3'b100; if3.sweep_start = 1'b1;
    step();
    if3.sweep_start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k == 2) if3.mode = 3'b000;
      step();
      chk($sformatf("w3xor_valid%0d", k), 32'(if3.out_valid),  32'd1);
      chk($sformatf("w3xor_vec%0d", k),   32'(if3.out_vec),    32'(k));
      chk($sformatf("w3xor_bit%0d", k),   32'(if3.out_bit),    32'(xor3_tt[k]));
      chk($sformatf("w3xor_done%0d", k),  32'(if3.sweep_done), 32'(k == 7));
    end
    chk("w3xor_ones", 32'(if3.ones_count), 32'd4);

    // W2: sweep_start and in_valid in the same IDLE cycle
    if2.mode = 3'b001; if2.in_data = 2'b11; if2.in_valid = 1'b1; if2.sweep_start = 1'b1;
    #1;
    chk("collide_in_ready", 32'(if2.in_ready), 32'd0);
    step();
    if2.sweep_start = 1'b0;
    chk("collide_dropped", 32'(if2.out_valid), 32'd0);
    chk("collide_ready_busy", 32'(if2.in_ready), 32'd0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("collide_vec%0d", k),  32'(if2.out_vec),    32'(k));
      chk($sformatf("collide_bit%0d", k),  32'(if2.out_bit),    32'(k != 0));
      chk($sformatf("collide_done%0d", k), 32'(if2.sweep_done), 32'(k == 3));
    end
    if2.in_valid = 1'b0;
    chk("collide_ones", 32'(if2.ones_count), 32'd3);

    // W4 OR sweep interrupted by reset in its 5th cycle
    if4.mode = 3'b001; if4.sweep_start = 1'b1;
    step();
    if4.sweep_start = 1'b0;
    for (int k = 0; k < 4; k++) step();
    chk("w4_pre_rst_vec",  32'(if4.out_vec),    32'd3);
    chk("w4_pre_rst_ones", 32'(if4.ones_count), 32'd3);
    rst_n = 1'b0;
    #1;
    chk("w4_arst_valid", 32'(if4.out_valid),  32'd0);
    chk("w4_arst_vec",   32'(if4.out_vec),    32'd0);
    chk("w4_arst_bit",   32'(if4.out_bit),    32'd0);
    chk("w4_arst_busy",  32'(if4.sweep_busy), 32'd0);
    chk("w4_arst_ones",  32'(if4.ones_count), 32'd0);
    step();
    chk("w4_arst_no_done", 32'(if4.sweep_done), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("w4_post_rst_ready", 32'(if4.in_ready), 32'd1);
    step();
    chk("w4_idle_no_done", 32'(if4.sweep_done), 32'd0);
    chk("w4_idle_busy",    32'(if4.sweep_busy), 32'd0);
    if4.sweep_start = 1'b1;
    step();
    if4.sweep_start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      step();
      chk($sformatf("w4or_vec%0d", k),  32'(if4.out_vec),    32'(k));
      chk($sformatf("w4or_bit%0d", k),  32'(if4.out_bit),    32'(or4_tt[k]));
      chk($sformatf("w4or_done%0d", k), 32'(if4.sweep_done), 32'(k == 15));
    end
    chk("w4or_ones", 32'(if4.ones_count), 32'd15);
    step();
    chk("w4or_busy_end", 32'(if4.sweep_busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/logic_gate_sweep.md
Name: logic_gate_sweep

Overview:
Parametrised N-input configurable logic gate with a registered output and a built-in truth-table sweep engine. In normal mode it evaluates single operand vectors through a valid/ready handshake. In sweep mode it generates all 2^WIDTH input combinations in ascending order, emits each result, and reports how many results were 1. It replaces the fixed 2-input gate plus hand-written stimulus bench as the gate-level self-check block for the assignment set.

Parameters:
WIDTH, 2, number of gate inputs; legal range 2..8.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
mode  input  3  gate function select (see Behaviour)
in_valid  input  1  operand vector valid (normal mode)
in_data  input  WIDTH  operand vector
in_ready  output  1  block can accept in_data this cycle
sweep_start  input  1  request exhaustive sweep (sampled in IDLE only)
out_valid  output  1  out_bit/out_vec valid, one-cycle pulse per result
out_bit  output  1  gate result
out_vec  output  WIDTH  operand vector that produced out_bit
sweep_busy  output  1  sweep in progress
sweep_done  output  1  one-cycle pulse with final sweep result
ones_count  output  WIDTH+1  number of 1 results in the last sweep

Behaviour:
- Clocking/reset: single clock domain, clk. rst_n is asynchronous and active-low; deassertion is synchronous to clk.
- Reset values: out_valid=0, out_bit=0, out_vec=0, sweep_busy=0, sweep_done=0, ones_count=0, FSM=IDLE. in_ready=1 after reset.
- Mode encoding, applied as a reduction over all WIDTH bits:
  - 000 AND, 001 OR, 010 NAND, 011 NOR, 100 XOR, 101 XNOR.
  - 110/111 are reserved; the result is 0, and out_valid still pulses.
- FSM states: IDLE and SWEEP.
- in_ready: in_ready = (state==IDLE) && !sweep_start. This is combinational, so sweep_start has priority over in_valid.
- Normal mode: a transfer occurs when in_valid && in_ready at a rising edge.
  - Latency is 1 cycle: on the next cycle out_valid=1, out_vec=in_data, out_bit=f(mode,in_data).
  - Back-to-back transfers give a continuous out_valid.
  - There is no output backpressure.
  - ones_count is not touched in normal mode.
- IDLE -> SWEEP: sweep_start=1 in IDLE at edge E0.
  - Latch mode into sweep_mode.
  - Clear the vector counter and ones_count to 0.
  - sweep_busy=1 from E0.
- SWEEP, at each edge Ek (k=1..2^WIDTH):
  - Register out_vec=counter and out_bit=f(sweep_mode,counter), with out_valid=1.
  - ones_count += out_bit.
  - counter += 1.
- SWEEP -> IDLE: at the edge where counter==all-ones (E(2^WIDTH)).
  - The same edge sets sweep_done=1 for one cycle, coincident with the last out_valid. ones_count already includes the last result.
  - sweep_busy=0 from that edge.
- Sweep timing: the sweep produces exactly 2^WIDTH contiguous results. Total latency from the sweep_start edge to sweep_done is 2^WIDTH cycles.
- Counter width: the counter is WIDTH bits, and its wrap-around terminates the sweep. ones_count at WIDTH+1 bits holds the maximum value 2^WIDTH without overflow.
- During SWEEP:
  - mode changes are ignored because sweep_mode is latched.
  - in_valid is ignored and dropped (in_ready=0).
  - sweep_start is ignored.
- ones_count holds its value after a sweep until the next sweep_start or reset.
- Reset mid-sweep: all outputs return to their reset values immediately. No sweep_done is produced, and the FSM returns to IDLE.

Test Plan:
- WIDTH=2, mode=011 (NOR), pulse sweep_start -> 4 results with out_vec 00,01,10,11 and out_bit 1,0,0,0; sweep_done on the 4th result; ones_count=1; sweep_busy high for exactly 4 cycles.
- WIDTH=2, normal mode NOR: in_data=10 valid -> next cycle out_bit=0, out_vec=10; then in_data=00 back-to-back -> out_bit=1 on the following cycle; out_valid high for 2 consecutive cycles.
- WIDTH=3, mode=100 (XOR) sweep; change mode to 000 after 2 cycles -> ones_count=4 (odd parity preserved, mode change ignored); out_vec runs 000..111 without gaps.
- sweep_start and in_valid asserted in the same IDLE cycle -> in_ready=0; operand dropped; the first result has out_vec=0.
- Assert rst_n=0 at the 5th cycle of a WIDTH=4 sweep -> outputs zero asynchronously; no sweep_done; after release in_ready=1 and a new sweep completes with ones_count=15 for mode=001 (OR).
- mode=110 in normal mode with in_data=11 -> out_valid=1, out_bit=0.
